alu_result_queue: RTL and testbench
===================================

// Module: alu_result_queue
// PURPOSE
//   Downstream stage of the 2-bit ALU. Captures each ALU result (y, op select, flags c/z/n/o)
//   on a valid/ready push, buffers it in a small FIFO and presents it to the consumer
//   (register file / display) through a valid/ready pop interface.
//   Also keeps sticky carry/overflow status and a saturating count of accepted operations.
// PARAMETERS
//   WIDTH  2  result width; equals the ALU datapath width
//   DEPTH  4  FIFO entries; power of two, >= 2
//   CNT_W  8  width of op_count
// PORTS
//   clk        in   1        clock; all state updates on the rising edge
//   rst_n      in   1        asynchronous reset, active low
//   in_valid   in   1        producer holds a valid ALU result this cycle
//   in_ready   out  1        queue can accept; equals ~full
//   in_op      in   2        ALU select: 00 add, 01 sub, 10 or, 11 and
//   in_y       in   WIDTH    ALU result
//   in_flags   in   4        {c,z,n,o} from the ALU
//   out_valid  out  1        head entry available; equals ~empty
//   out_ready  in   1        consumer takes the head entry this cycle
//   out_op     out  2        op of the head entry
//   out_y      out  WIDTH    result of the head entry
//   out_flags  out  4        {c,z,n,o} of the head entry
//   level      out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
//   sticky_c   out  1        set when any accepted entry had c=1
//   sticky_o   out  1        set when any accepted entry had o=1
//   sticky_clr in   1        synchronous clear of sticky_c and sticky_o
//   op_count   out  CNT_W    accepted pushes; saturates at 2**CNT_W-1
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): pointers=0, level=0, out_valid=0, in_ready=1,
//     sticky_c=0, sticky_o=0, op_count=0. Storage contents are don't-care.
//     A reset mid-transfer discards all stored entries; no push or pop in that cycle.
//   Push = in_valid & in_ready; pop = out_valid & out_ready (evaluated at the clock edge).
//   Storage: circular buffer with DEPTH entries of {op, y, flags}; write pointer advances
//     on push, read pointer advances on pop; both wrap from DEPTH-1 to 0.
//   out_op/out_y/out_flags are read combinationally from the read pointer; they are valid
//     only while out_valid=1.
//   Latency: an entry pushed at edge k appears on out_* with out_valid=1 after edge k.
//     No same-cycle bypass: an empty queue keeps out_valid=0 during the push cycle.
//   level: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
//   Full (level=DEPTH): in_ready=0, and a push in the same cycle as a pop is NOT accepted.
//     The producer must hold its data until in_ready=1.
//   Empty (level=0): out_valid=0, and out_ready is ignored.
//   Push+pop with 0<level<DEPTH: both occur and level is unchanged.
//   Producer rule: in_* must stay stable while in_valid=1 and in_ready=0.
//   Consumer rule: out_* stay stable while out_valid=1 and out_ready=0.
//   Sticky flags: on push, sticky_c |= in_flags[3] and sticky_o |= in_flags[0].
//     sticky_clr=1 with no set event: clear to 0.
//     sticky_clr=1 in the same cycle as a setting push: the set wins and the bit ends at 1.
//   op_count: +1 on each push; holds at all-ones and does not wrap.
//   No flag recomputation is done: flags are stored exactly as received.
// TESTING
//   1. Reset, then push op=00, y=2'b01, flags=4'b0000
//      -> next cycle out_valid=1, out_y=01, level=1, op_count=1.
//   2. Push 4 entries (y=0,1,2,3) with out_ready=0 -> level=4, in_ready=0.
//      A 5th in_valid is held off. Then pop 4 -> out_y sequence 0,1,2,3, then out_valid=0.
//   3. level=4, in_valid=1 and out_ready=1 in the same cycle
//      -> only the pop occurs, level=3, next cycle in_ready=1.
//   4. level=2, push+pop every cycle for 10 cycles -> level stays 2,
//      data stays in FIFO order across pointer wrap.
//   5. Push flags=4'b1001 together with sticky_clr=1 -> sticky_c=1, sticky_o=1.
//      Next cycle sticky_clr=1 with no push -> both clear to 0.
//   6. Assert rst_n=0 between clock edges with level=3 -> out_valid=0 and level=0
//      immediately, before the next clock edge. CNT_W=2 run: after 5 pushes op_count=3.

Source files
------------

// File: rtl/alu_result_queue.sv
// Result FIFO behind the 2-bit ALU: buffers {op, y, flags} between a valid/ready producer
// and consumer, and tracks sticky carry/overflow plus a saturating accepted-op count.
module alu_result_queue #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_op,
   input  logic [WIDTH-1:0]           in_y,
   input  logic [3:0]                 in_flags,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_op,
   output logic [WIDTH-1:0]           out_y,
   output logic [3:0]                 out_flags,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sticky_c,
   output logic                       sticky_o,
   input  logic                       sticky_clr,
   output logic [CNT_W-1:0]           op_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] y;
      logic [3:0]       flags;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   entry_t           head;

   // Full blocks a push even when a pop happens in the same cycle.
   assign full      = (level == LVL_W'(DEPTH));
   assign empty     = (level == '0);
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign head      = mem[rd_ptr];
   assign out_op    = head.op;
   assign out_y     = head.y;
   assign out_flags = head.flags;

   // NOTE: storage is deliberately left out of reset; only pointers/level decide validity,
   // so the array maps onto plain registers or RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{op: in_op, y: in_y, flags: in_flags};
      end
   end

   // NOTE: state registers use non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // A setting push wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_c <= 1'b0;
         sticky_o <= 1'b0;
         op_count <= '0;
      end else begin
         sticky_c <= (sticky_c & ~sticky_clr) | (push & in_flags[3]);
         sticky_o <= (sticky_o & ~sticky_clr) | (push & in_flags[0]);
         if (push && (op_count != '1)) op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: one task per scenario with inline expected values.
// A second instance with CNT_W=2 shares the inputs to exercise op_count saturation.
module tb_alu_result_queue;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_op;
   logic [1:0] in_y;
   logic [3:0] in_flags;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_op;
   logic [1:0] out_y;
   logic [3:0] out_flags;
   logic [2:0] level;
   logic       sticky_c;
   logic       sticky_o;
   logic       sticky_clr;
   logic [7:0] op_count;

   logic       s_in_ready;
   logic       s_out_valid;
   logic [1:0] s_out_op;
   logic [1:0] s_out_y;
   logic [3:0] s_out_flags;
   logic [2:0] s_level;
   logic       s_sticky_c;
   logic       s_sticky_o;
   logic [1:0] s_op_count;

   int passed = 0;
   int total  = 0;

   alu_result_queue #(.WIDTH(2), .DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_y(in_y), .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_y(out_y), .out_flags(out_flags), .level(level),
      .sticky_c(sticky_c), .sticky_o(sticky_o), .sticky_clr(sticky_clr), .op_count(op_count)
   );

   alu_result_queue #(.WIDTH(2), .DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
      .in_y(in_y), .in_flags(in_flags), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_op(s_out_op), .out_y(s_out_y), .out_flags(s_out_flags), .level(s_level),
      .sticky_c(s_sticky_c), .sticky_o(s_sticky_o), .sticky_clr(sticky_clr),
      .op_count(s_op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      in_op      = 2'd0;
      in_y       = 2'd0;
      in_flags   = 4'd0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic push_one(input logic [1:0] op, input logic [1:0] y, input logic [3:0] flags);
      in_valid = 1'b1;
      in_op    = op;
      in_y     = y;
      in_flags = flags;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      total++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (op_count !== 8'd0) $display("FAIL reset_op_count: got %0d want 0", op_count); else passed++;
      total++; if ({sticky_c, sticky_o} !== 2'b00) $display("FAIL reset_sticky: got %b want 00", {sticky_c, sticky_o}); else passed++;
   endtask

   task automatic test_single_push();
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_y     = 2'b01;
      in_flags = 4'b0000;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL no_bypass: got out_valid %b want 0", out_valid); else passed++;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else passed++;
      total++; if (out_y !== 2'b01) $display("FAIL single_out_y: got %b want 01", out_y); else passed++;
      total++; if (out_op !== 2'b00) $display("FAIL single_out_op: got %b want 00", out_op); else passed++;
      total++; if (level !== 3'd1) $display("FAIL single_level: got %0d want 1", level); else passed++;
      total++; if (op_count !== 8'd1) $display("FAIL single_op_count: got %0d want 1", op_count); else passed++;
   endtask

   task automatic test_fill_drain();
      logic [1:0] v;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         push_one(v, v, {2'b01, v});
      end
      total++; if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passed++;
      push_one(2'b10, 2'b10, 4'b1111);
      total++; if (level !== 3'd4) $display("FAIL held_off_level: got %0d want 4", level); else passed++;
      total++; if (op_count !== 8'd4) $display("FAIL held_off_op_count: got %0d want 4", op_count); else passed++;
      total++; if (sticky_c !== 1'b0) $display("FAIL held_off_sticky_c: got %b want 0", sticky_c); else passed++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = 2'(i);
         total++; if (out_valid !== 1'b1) $display("FAIL drain_valid_%0d: got %b want 1", i, out_valid); else passed++;
         total++; if (out_y !== v) $display("FAIL drain_y_%0d: got %0d want %0d", i, out_y, v); else passed++;
         total++; if (out_flags !== {2'b01, v}) $display("FAIL drain_flags_%0d: got %b want %b", i, out_flags, {2'b01, v}); else passed++;
         tick();
      end
      total++; if (out_valid !== 1'b0) $display("FAIL drained_out_valid: got %b want 0", out_valid); else passed++;
      tick();
      out_ready = 1'b0;
      total++; if (level !== 3'd0) $display("FAIL empty_pop_ignored: got level %0d want 0", level); else passed++;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) push_one(2'b01, 2'(i), 4'b0000);
      in_valid  = 1'b1;
      in_y      = 2'd2;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++; if (level !== 3'd3) $display("FAIL full_pp_level: got %0d want 3", level); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL full_pp_in_ready: got %b want 1", in_ready); else passed++;
      total++; if (out_y !== 2'd1) $display("FAIL full_pp_head: got %0d want 1", out_y); else passed++;
      total++; if (op_count !== 8'd4) $display("FAIL full_pp_op_count: got %0d want 4", op_count); else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      push_one(2'd0, 2'd0, 4'd0);
      push_one(2'd1, 2'd1, 4'd1);
      // Entry k carries y=op=k mod 4 and flags=k, so the head at cycle i is entry i.
      for (int i = 0; i < 10; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_op     = 2'(i + 2);
         in_y      = 2'(i + 2);
         in_flags  = 4'(i + 2);
         #1;
         total++; if ({out_op, out_y, out_flags} !== {2'(i), 2'(i), 4'(i)})
            $display("FAIL b2b_head_%0d: got %h want %h", i, {out_op, out_y, out_flags}, {2'(i), 2'(i), 4'(i)});
         else passed++;
         tick();
         total++; if (level !== 3'd2) $display("FAIL b2b_level_%0d: got %0d want 2", i, level); else passed++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++; if (op_count !== 8'd12) $display("FAIL b2b_op_count: got %0d want 12", op_count); else passed++;
   endtask

   task automatic test_sticky();
      do_reset();
      sticky_clr = 1'b1;
      push_one(2'b00, 2'b00, 4'b1001);
      total++; if ({sticky_c, sticky_o} !== 2'b11) $display("FAIL sticky_set_wins: got %b want 11", {sticky_c, sticky_o}); else passed++;
      tick();
      sticky_clr = 1'b0;
      total++; if ({sticky_c, sticky_o} !== 2'b00) $display("FAIL sticky_clear: got %b want 00", {sticky_c, sticky_o}); else passed++;
      push_one(2'b00, 2'b00, 4'b1000);
      total++; if ({sticky_c, sticky_o} !== 2'b10) $display("FAIL sticky_c_only: got %b want 10", {sticky_c, sticky_o}); else passed++;
      push_one(2'b00, 2'b00, 4'b0000);
      total++; if ({sticky_c, sticky_o} !== 2'b10) $display("FAIL sticky_holds: got %b want 10", {sticky_c, sticky_o}); else passed++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) push_one(2'b11, 2'(i), 4'b1001);
      total++; if (level !== 3'd3) $display("FAIL pre_reset_level: got %0d want 3", level); else passed++;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %b want 0", out_valid); else passed++;
      total++; if (level !== 3'd0) $display("FAIL async_level: got %0d want 0", level); else passed++;
      total++; if ({sticky_c, sticky_o, in_ready} !== 3'b001) $display("FAIL async_misc: got %b want 001", {sticky_c, sticky_o, in_ready}); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 3; i++) push_one(2'b00, 2'(i), 4'b0000);
      total++; if (s_op_count !== 2'd3) $display("FAIL sat_at_max: got %0d want 3", s_op_count); else passed++;
      push_one(2'b00, 2'd3, 4'b0000);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      push_one(2'b00, 2'd0, 4'b0000);
      total++; if (s_op_count !== 2'd3) $display("FAIL sat_holds: got %0d want 3", s_op_count); else passed++;
      total++; if (op_count !== 8'd5) $display("FAIL wide_count: got %0d want 5", op_count); else passed++;
      total++; if (s_level !== 3'd4) $display("FAIL sat_level: got %0d want 4", s_level); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_drain();
      test_full_push_pop();
      test_back_to_back();
      test_sticky();
      test_async_reset();
      test_saturation();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
